// File: rtl/prfc_pkg.sv
// prfc_pkg: shared types and constants for the classifier lookup dispatcher.
//   disp_state_e    - dispatcher FSM states
//   PRFC_DIM_WIDTH  - default width of one packet dimension
//   NUM_DIMS        - number of header dimensions per lookup
//   PRFC_NO_MATCH   - default result reported when a lookup times out
package prfc_pkg;
    localparam int PRFC_DIM_WIDTH = 16;
    localparam int NUM_DIMS = 6;
    localparam logic [31:0] PRFC_NO_MATCH = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FLUSH} disp_state_e;
endpackage

// File: rtl/prfc_timeout_counter.sv
// prfc_timeout_counter: cycle counter that flags expiry on its TIMEOUT_CYCLES-th enabled cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to zero (wins over en)
//   en         - count one cycle
//   expire     - counter has reached TIMEOUT_CYCLES-1
module prfc_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (clr) cnt_q <= '0;
        else if (en) cnt_q <= cnt_q + 1'b1;
    end
    assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/prfc_lookup_dispatcher.sv
// prfc_lookup_dispatcher: issues one classifier lookup per accepted header and returns result+tag.
//   hdr_valid/hdr_ready, hdr_dims_0..5, hdr_tag   - tagged header input stream
//   start_lookup, packet_dims_0..5                - lookup request to the classifier
//   lookup_done, lookup_result                    - classifier completion
//   res_valid/res_ready, res_result, res_tag,
//   res_timeout                                   - result output stream
//   busy, stat_timeout_cnt                        - status: not idle, saturating timeout count
module prfc_lookup_dispatcher
    import prfc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH = PRFC_DIM_WIDTH,
    parameter int TAG_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] NO_MATCH_RESULT = DATA_WIDTH'(PRFC_NO_MATCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hdr_valid,
    output logic                  hdr_ready,
    input  logic [DIM_WIDTH-1:0]  hdr_dims_0,
    input  logic [DIM_WIDTH-1:0]  hdr_dims_1,
    input  logic [DIM_WIDTH-1:0]  hdr_dims_2,
    input  logic [DIM_WIDTH-1:0]  hdr_dims_3,
    input  logic [DIM_WIDTH-1:0]  hdr_dims_4,
    input  logic [DIM_WIDTH-1:0]  hdr_dims_5,
    input  logic [TAG_WIDTH-1:0]  hdr_tag,
    output logic                  start_lookup,
    output logic [DIM_WIDTH-1:0]  packet_dims_0,
    output logic [DIM_WIDTH-1:0]  packet_dims_1,
    output logic [DIM_WIDTH-1:0]  packet_dims_2,
    output logic [DIM_WIDTH-1:0]  packet_dims_3,
    output logic [DIM_WIDTH-1:0]  packet_dims_4,
    output logic [DIM_WIDTH-1:0]  packet_dims_5,
    input  logic                  lookup_done,
    input  logic [DATA_WIDTH-1:0] lookup_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_result,
    output logic [TAG_WIDTH-1:0]  res_tag,
    output logic                  res_timeout,
    output logic                  busy,
    output logic [15:0]           stat_timeout_cnt
);
    disp_state_e state_q, state_d;
    logic [DIM_WIDTH-1:0] dims_q [NUM_DIMS];
    logic [DIM_WIDTH-1:0] hdr_dims [NUM_DIMS];
    logic [TAG_WIDTH-1:0] tag_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic timeout_q;
    logic [15:0] stat_q;
    logic capture, take_done, take_to, cnt_clr, cnt_en, expire;

    assign hdr_dims = '{hdr_dims_0, hdr_dims_1, hdr_dims_2, hdr_dims_3, hdr_dims_4, hdr_dims_5};

    prfc_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(cnt_en), .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    // The counter is cleared in ISSUE and RESP so both WAIT and FLUSH start from zero.
    // In WAIT a done arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        take_done = 1'b0;
        take_to = 1'b0;
        cnt_clr = 1'b0;
        cnt_en = 1'b0;
        case (state_q)
            IDLE: if (hdr_valid) begin
                capture = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_en = 1'b1;
                take_done = lookup_done;
                take_to = !lookup_done && expire;
                state_d = (lookup_done || expire) ? RESP : WAIT;
            end
            RESP: begin
                cnt_clr = 1'b1;
                state_d = res_ready ? (timeout_q ? FLUSH : IDLE) : RESP;
            end
            FLUSH: begin
                cnt_en = 1'b1;
                state_d = (lookup_done || expire) ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dims_q <= '{default: '0};
            tag_q <= '0;
            result_q <= '0;
            timeout_q <= 1'b0;
            stat_q <= '0;
        end else begin
            if (capture) begin
                dims_q <= hdr_dims;
                tag_q <= hdr_tag;
            end
            if (take_done) begin
                result_q <= lookup_result;
                timeout_q <= 1'b0;
            end
            if (take_to) begin
                result_q <= NO_MATCH_RESULT;
                timeout_q <= 1'b1;
                stat_q <= stat_q + {15'd0, stat_q != 16'hFFFF};
            end
        end
    end

    assign hdr_ready = state_q == IDLE;
    assign start_lookup = state_q == ISSUE;
    assign res_valid = state_q == RESP;
    assign busy = state_q != IDLE;
    assign packet_dims_0 = dims_q[0];
    assign packet_dims_1 = dims_q[1];
    assign packet_dims_2 = dims_q[2];
    assign packet_dims_3 = dims_q[3];
    assign packet_dims_4 = dims_q[4];
    assign packet_dims_5 = dims_q[5];
    assign res_result = result_q;
    assign res_tag = tag_q;
    assign res_timeout = timeout_q;
    assign stat_timeout_cnt = stat_q;
endmodule

// File: tb/tb_prfc_lookup_dispatcher.sv
// tb_prfc_lookup_dispatcher: directed self-checking bench for the lookup dispatcher (TIMEOUT_CYCLES=8).
module tb_prfc_lookup_dispatcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hdr_valid = 1'b0;
    logic hdr_ready;
    logic [15:0] hd0 = '0, hd1 = '0, hd2 = '0, hd3 = '0, hd4 = '0, hd5 = '0;
    logic [7:0] hdr_tag = '0;
    logic start_lookup;
    logic [15:0] pd0, pd1, pd2, pd3, pd4, pd5;
    logic lookup_done = 1'b0;
    logic [31:0] lookup_result = '0;
    logic res_valid;
    logic res_ready = 1'b1;
    logic [31:0] res_result;
    logic [7:0] res_tag;
    logic res_timeout;
    logic busy;
    logic [15:0] stat_timeout_cnt;
    int total = 0;
    int bad = 0;

    prfc_lookup_dispatcher #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_dims_0(hd0), .hdr_dims_1(hd1), .hdr_dims_2(hd2),
        .hdr_dims_3(hd3), .hdr_dims_4(hd4), .hdr_dims_5(hd5),
        .hdr_tag(hdr_tag), .start_lookup(start_lookup),
        .packet_dims_0(pd0), .packet_dims_1(pd1), .packet_dims_2(pd2),
        .packet_dims_3(pd3), .packet_dims_4(pd4), .packet_dims_5(pd5),
        .lookup_done(lookup_done), .lookup_result(lookup_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_result(res_result),
        .res_tag(res_tag), .res_timeout(res_timeout), .busy(busy),
        .stat_timeout_cnt(stat_timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_hdr(input logic [15:0] d0, input logic [7:0] tag);
        hd0 = d0; hd1 = d0 + 16'd1; hd2 = d0 + 16'd2;
        hd3 = d0 + 16'd3; hd4 = d0 + 16'd4; hd5 = d0 + 16'd5;
        hdr_tag = tag;
    endtask

    // Accept a header from IDLE and land in ISSUE.
    task automatic send(input logic [15:0] d0, input logic [7:0] tag, input string nm);
        set_hdr(d0, tag);
        hdr_valid = 1'b1;
        step();
        hdr_valid = 1'b0;
        chk({nm, "_start"}, 64'(start_lookup), 64'd1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_hdr_ready", 64'(hdr_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(start_lookup), 64'd0);
        chk("rst_dims0", 64'(pd0), 64'd0);
        chk("rst_stat", 64'(stat_timeout_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1. Basic lookup, done 3 cycles after start
        send(16'd1, 8'h5A, "t1");
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_hdr_ready", 64'(hdr_ready), 64'd0);
        chk("t1_dims0", 64'(pd0), 64'd1);
        chk("t1_dims3", 64'(pd3), 64'd4);
        chk("t1_dims5", 64'(pd5), 64'd6);
        step();
        chk("t1_start_once", 64'(start_lookup), 64'd0);
        step();
        step();
        lookup_done = 1'b1;
        lookup_result = 32'h0000_0007;
        step();
        lookup_done = 1'b0;
        chk("t1_res_valid", 64'(res_valid), 64'd1);
        chk("t1_res_result", 64'(res_result), 64'h7);
        chk("t1_res_tag", 64'(res_tag), 64'h5A);
        chk("t1_res_timeout", 64'(res_timeout), 64'd0);
        step();
        chk("t1_idle_valid", 64'(res_valid), 64'd0);
        chk("t1_idle_ready", 64'(hdr_ready), 64'd1);

        // 2. Back-pressure for 10 cycles
        res_ready = 1'b0;
        send(16'd10, 8'h33, "t2");
        step();
        lookup_done = 1'b1;
        lookup_result = 32'hABCD_0001;
        step();
        lookup_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", 64'(res_valid), 64'd1);
            chk("t2_hold_result", 64'(res_result), 64'hABCD_0001);
            chk("t2_hold_tag", 64'(res_tag), 64'h33);
            chk("t2_hold_hdr_ready", 64'(hdr_ready), 64'd0);
            chk("t2_hold_dims0", 64'(pd0), 64'd10);
            step();
        end
        set_hdr(16'h0100, 8'hC3);
        hdr_valid = 1'b1;
        res_ready = 1'b1;
        step();
        chk("t2_release_valid", 64'(res_valid), 64'd0);
        chk("t2_release_ready", 64'(hdr_ready), 64'd1);
        step();
        hdr_valid = 1'b0;
        chk("t2_next_start", 64'(start_lookup), 64'd1);
        chk("t2_next_dims0", 64'(pd0), 64'h0100);

        // 3. Timeout: classifier never answers
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_wait_no_valid", 64'(res_valid), 64'd0);
        end
        step();
        chk("t3_to_valid", 64'(res_valid), 64'd1);
        chk("t3_to_result", 64'(res_result), 64'hFFFF_FFFF);
        chk("t3_to_flag", 64'(res_timeout), 64'd1);
        chk("t3_to_tag", 64'(res_tag), 64'hC3);
        chk("t3_to_stat", 64'(stat_timeout_cnt), 64'd1);
        step();
        chk("t3_flush_valid", 64'(res_valid), 64'd0);
        chk("t3_flush_busy", 64'(busy), 64'd1);
        chk("t3_flush_hdr_ready", 64'(hdr_ready), 64'd0);
        step();
        lookup_done = 1'b1;
        lookup_result = 32'hDEAD_BEEF;
        step();
        lookup_done = 1'b0;
        chk("t3_drain_idle", 64'(busy), 64'd0);
        chk("t3_drain_no_valid", 64'(res_valid), 64'd0);
        chk("t3_drain_stat", 64'(stat_timeout_cnt), 64'd1);
        send(16'd7, 8'h11, "t3b");
        lookup_done = 1'b1;
        lookup_result = 32'h42;
        step();
        lookup_done = 1'b0;
        chk("t3b_wait", 64'(res_valid), 64'd0);
        lookup_done = 1'b1;
        step();
        lookup_done = 1'b0;
        chk("t3b_result", 64'(res_result), 64'h42);
        chk("t3b_timeout", 64'(res_timeout), 64'd0);
        chk("t3b_tag", 64'(res_tag), 64'h11);
        step();

        // 4. Done on the final WAIT cycle wins over the timeout
        send(16'd20, 8'h44, "t4");
        for (int i = 0; i < 8; i++) step();
        chk("t4_last_wait", 64'(res_valid), 64'd0);
        lookup_done = 1'b1;
        lookup_result = 32'h99;
        step();
        lookup_done = 1'b0;
        chk("t4_valid", 64'(res_valid), 64'd1);
        chk("t4_result", 64'(res_result), 64'h99);
        chk("t4_timeout", 64'(res_timeout), 64'd0);
        chk("t4_stat", 64'(stat_timeout_cnt), 64'd1);
        step();
        chk("t4_back_idle", 64'(busy), 64'd0);

        // 5. Spurious done in IDLE and in ISSUE
        lookup_done = 1'b1;
        lookup_result = 32'h55;
        step();
        chk("t5_idle_no_valid", 64'(res_valid), 64'd0);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        lookup_done = 1'b0;
        send(16'd30, 8'h66, "t5");
        lookup_done = 1'b1;
        step();
        lookup_done = 1'b0;
        chk("t5_issue_ignored", 64'(res_valid), 64'd0);
        chk("t5_in_wait", 64'(busy), 64'd1);
        step();
        chk("t5_still_wait", 64'(res_valid), 64'd0);
        lookup_done = 1'b1;
        lookup_result = 32'h77;
        step();
        lookup_done = 1'b0;
        chk("t5_result", 64'(res_result), 64'h77);
        chk("t5_tag", 64'(res_tag), 64'h66);
        step();

        // 6. Asynchronous reset mid-WAIT
        send(16'd40, 8'h88, "t6");
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_hdr_ready", 64'(hdr_ready), 64'd1);
        chk("t6_rst_dims0", 64'(pd0), 64'd0);
        chk("t6_rst_start", 64'(start_lookup), 64'd0);
        chk("t6_rst_stat", 64'(stat_timeout_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_after_ready", 64'(hdr_ready), 64'd1);
        chk("t6_after_valid", 64'(res_valid), 64'd0);
        send(16'd50, 8'h99, "t6b");
        chk("t6b_dims0", 64'(pd0), 64'd50);
        lookup_done = 1'b0;
        step();
        lookup_done = 1'b1;
        lookup_result = 32'h1234;
        step();
        lookup_done = 1'b0;
        chk("t6b_valid", 64'(res_valid), 64'd1);
        chk("t6b_result", 64'(res_result), 64'h1234);
        chk("t6b_tag", 64'(res_tag), 64'h99);
        step();
        chk("t6b_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
